// File: rtl/alu_pkg.sv
// Shared widths, FSM state type and opcodes for the
// two-requester ALU arbiter.
package alu_pkg;

  localparam int DW    = 4;
  localparam int OW    = 2;
  localparam int RW    = 5;
  localparam int CNT_W = 8;

  localparam logic [OW-1:0] OP_ADD = 2'b00;
  localparam logic [OW-1:0] OP_SUB = 2'b01;
  localparam logic [OW-1:0] OP_AND = 2'b10;
  localparam logic [OW-1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle for both
// requesters of the ALU arbiter.
interface alu_arbiter_if
  import alu_pkg::*;
();

  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic [OW-1:0] req0_op;
  logic          rsp0_valid;
  logic [RW-1:0] rsp0_data;
  logic          rsp0_ready;

  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [OW-1:0] req1_op;
  logic          rsp1_valid;
  logic [RW-1:0] rsp1_data;
  logic          rsp1_ready;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req0_op, rsp0_ready,
    input  req0_ready, rsp0_valid, rsp0_data,
    output req1_valid, req1_a, req1_b,
    output req1_op, rsp1_ready,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req0_op, rsp0_ready,
    output req0_ready, rsp0_valid, rsp0_data,
    input  req1_valid, req1_a, req1_b,
    input  req1_op, rsp1_ready,
    output req1_ready, rsp1_valid, rsp1_data
  );

endinterface

// File: rtl/alu_machine.sv
// Combinational 4-bit ALU: extra is carry on add,
// borrow on subtract, zero for logic ops.
module alu_machine
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [OW-1:0] op,
  output logic [DW-1:0] out,
  output logic          extra
);

  logic [RW-1:0] res;

  always_comb begin
    res = '0;
    unique case (op)
      OP_ADD: res = {1'b0, a} + {1'b0, b};
      OP_SUB: res = {1'b0, a} - {1'b0, b};
      OP_AND: res = {1'b0, a & b};
      OP_XOR: res = {1'b0, a ^ b};
      default: res = '0;
    endcase
  end

  assign out   = res[DW-1:0];
  assign extra = res[RW-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two
// requesters: IDLE accept, EXEC compute, RESP hold.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] ops_done
);

  state_t        state;
  logic          ptr;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [OW-1:0] op_q;
  logic [RW-1:0] res_q;
  logic [DW-1:0] alu_out;
  logic          alu_extra;
  logic          pick;
  logic          acc;
  logic          done;
  logic          in_resp;

  // ptr only decides a tie; a lone requester always wins
  assign pick = (bus.req0_valid & bus.req1_valid)
              ? ptr : bus.req1_valid;

  assign acc = rst_n & (state == S_IDLE)
             & (bus.req0_valid | bus.req1_valid);

  assign bus.req0_ready = acc & ~pick;
  assign bus.req1_ready = acc & pick;

  assign in_resp = (state == S_RESP);
  assign done    = in_resp & (grant_id ? bus.rsp1_ready
                                       : bus.rsp0_ready);

  assign bus.rsp0_valid = in_resp & ~grant_id;
  assign bus.rsp1_valid = in_resp & grant_id;
  assign bus.rsp0_data  = bus.rsp0_valid ? res_q : '0;
  assign bus.rsp1_data  = bus.rsp1_valid ? res_q : '0;

  assign busy = (state != S_IDLE);

  alu_machine u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .out   (alu_out),
    .extra (alu_extra)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= RR_INIT;
      grant_id <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      ops_done <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (acc) begin
            a_q      <= pick ? bus.req1_a : bus.req0_a;
            b_q      <= pick ? bus.req1_b : bus.req0_b;
            op_q     <= pick ? bus.req1_op : bus.req0_op;
            grant_id <= pick;
            ptr      <= ~pick;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q <= {alu_extra, alu_out};
          state <= S_RESP;
        end
        S_RESP: begin
          if (done) begin
            ops_done <= ops_done + 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single
// ops plus contention, backpressure, reset and wrap.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic       grant_id;
  logic [7:0] ops_done;

  int errors = 0;
  int checks = 0;
  int exp_ops = 0;

  alu_arbiter_if bus ();

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] model(
    logic [3:0] a, logic [3:0] b, logic [1:0] op);
    case (op)
      2'd0: return {1'b0, a} + {1'b0, b};
      2'd1: return {(a < b), 4'(a - b)};
      2'd2: return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  task automatic set_req(logic id, logic v, logic [3:0] a,
                         logic [3:0] b, logic [1:0] op);
    if (id) begin
      bus.req1_valid = v;
      bus.req1_a = a;
      bus.req1_b = b;
      bus.req1_op = op;
    end else begin
      bus.req0_valid = v;
      bus.req0_a = a;
      bus.req0_b = b;
      bus.req0_op = op;
    end
  endtask

  function automatic logic rdy(logic id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rv(logic id);
    return id ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  function automatic logic [4:0] rd(logic id);
    return id ? bus.rsp1_data : bus.rsp0_data;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_op(string nm, logic id, logic [3:0] a,
                       logic [3:0] b, logic [1:0] op,
                       logic [4:0] exp);
    set_req(id, 1'b1, a, b, op);
    #1;
    chk({nm, "_rdy"}, 32'(rdy(id)), 1);
    chk({nm, "_other_rdy"}, 32'(rdy(!id)), 0);
    cyc();
    set_req(id, 1'b0, 4'd0, 4'd0, 2'd0);
    chk({nm, "_busy"}, 32'(busy), 1);
    chk({nm, "_gid"}, 32'(grant_id), 32'(id));
    chk({nm, "_early_v"}, 32'(rv(id)), 0);
    cyc();
    chk({nm, "_rv"}, 32'(rv(id)), 1);
    chk({nm, "_rd"}, 32'(rd(id)), 32'(exp));
    chk({nm, "_other_rv"}, 32'(rv(!id)), 0);
    chk({nm, "_other_rd"}, 32'(rd(!id)), 0);
    cyc();
    exp_ops = (exp_ops + 1) % 256;
    chk({nm, "_ops"}, 32'(ops_done), 32'(exp_ops));
    chk({nm, "_idle"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    exp_ops = 0;
  endtask

  initial begin
    logic [7:0] k;
    logic [4:0] held;
    tbl[0] = '{1'b0, 4'd3,  4'd4,  2'd0, 5'h07};
    tbl[1] = '{1'b1, 4'd15, 4'd1,  2'd0, 5'h10};
    tbl[2] = '{1'b0, 4'd15, 4'd15, 2'd0, 5'h1E};
    tbl[3] = '{1'b1, 4'd2,  4'd5,  2'd1, 5'h1D};
    tbl[4] = '{1'b0, 4'd9,  4'd9,  2'd1, 5'h00};
    tbl[5] = '{1'b1, 4'd12, 4'd10, 2'd2, 5'h08};
    tbl[6] = '{1'b0, 4'd6,  4'd3,  2'd3, 5'h05};
    tbl[7] = '{1'b1, 4'd15, 4'd0,  2'd1, 5'h0F};

    set_req(1'b0, 1'b1, 4'd1, 4'd1, 2'd0);
    set_req(1'b1, 1'b0, 4'd0, 4'd0, 2'd0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;

    // reset state with a request already pending
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_ops", 32'(ops_done), 0);
    chk("rst_rdy0", 32'(bus.req0_ready), 0);
    chk("rst_rv0", 32'(bus.rsp0_valid), 0);
    chk("rst_rd1", 32'(bus.rsp1_data), 0);
    set_req(1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
    rst_n = 1'b1;

    foreach (tbl[i])
      do_op($sformatf("tbl%0d", i), tbl[i].id, tbl[i].a,
            tbl[i].b, tbl[i].op, tbl[i].exp);

    // contention from reset: alternate 0,1,0,1
    do_reset();
    set_req(1'b0, 1'b1, 4'd1, 4'd1, 2'd0);
    set_req(1'b1, 1'b1, 4'd8, 4'd8, 2'd0);
    for (int n = 0; n < 4; n++) begin
      logic id;
      id = n[0];
      #1;
      chk($sformatf("cont%0d_rdy", n), 32'(rdy(id)), 1);
      chk($sformatf("cont%0d_nrdy", n), 32'(rdy(!id)), 0);
      cyc();
      chk($sformatf("cont%0d_gid", n), 32'(grant_id),
          32'(id));
      chk($sformatf("cont%0d_exec_rdy", n),
          32'(bus.req0_ready | bus.req1_ready), 0);
      cyc();
      chk($sformatf("cont%0d_rv", n), 32'(rv(id)), 1);
      chk($sformatf("cont%0d_rd", n), 32'(rd(id)),
          id ? 32'h10 : 32'h02);
      cyc();
      exp_ops++;
      chk($sformatf("cont%0d_ops", n), 32'(ops_done),
          32'(exp_ops));
    end
    set_req(1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
    set_req(1'b1, 1'b0, 4'd0, 4'd0, 2'd0);

    // backpressure on requester 1
    bus.rsp1_ready = 1'b0;
    set_req(1'b1, 1'b1, 4'd5, 4'd3, 2'd1);
    #1;
    chk("bp_rdy1", 32'(bus.req1_ready), 1);
    cyc();
    set_req(1'b1, 1'b0, 4'd0, 4'd0, 2'd0);
    set_req(1'b0, 1'b1, 4'd7, 4'd7, 2'd2);
    cyc();
    held = 5'h02;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("bp%0d_rv1", n), 32'(bus.rsp1_valid), 1);
      chk($sformatf("bp%0d_rd1", n), 32'(bus.rsp1_data),
          32'(held));
      chk($sformatf("bp%0d_busy", n), 32'(busy), 1);
      chk($sformatf("bp%0d_rdy0", n), 32'(bus.req0_ready), 0);
      cyc();
    end
    bus.rsp1_ready = 1'b1;
    #1;
    chk("bp_rel_rdy0", 32'(bus.req0_ready), 0);
    cyc();
    exp_ops++;
    chk("bp_ops", 32'(ops_done), 32'(exp_ops));
    do_op("bp_r0", 1'b0, 4'd7, 4'd7, 2'd2, 5'h07);

    // late request on 1 while 0 is executing
    set_req(1'b0, 1'b1, 4'd2, 4'd2, 2'd0);
    #1;
    chk("late_rdy0", 32'(bus.req0_ready), 1);
    cyc();
    set_req(1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
    set_req(1'b1, 1'b1, 4'd9, 4'd4, 2'd1);
    #1;
    chk("late_exec_rdy1", 32'(bus.req1_ready), 0);
    cyc();
    chk("late_resp_rdy1", 32'(bus.req1_ready), 0);
    chk("late_rd0", 32'(bus.rsp0_data), 32'h04);
    cyc();
    exp_ops++;
    chk("late_ops", 32'(ops_done), 32'(exp_ops));
    do_op("late_r1", 1'b1, 4'd9, 4'd4, 2'd1, 5'h05);

    // reset while executing discards the op
    set_req(1'b0, 1'b1, 4'd4, 4'd4, 2'd0);
    cyc();
    set_req(1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
    set_req(1'b1, 1'b1, 4'd1, 4'd2, 2'd0);
    chk("mid_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_gid", 32'(grant_id), 0);
    chk("mid_ops", 32'(ops_done), 0);
    chk("mid_rdy1", 32'(bus.req1_ready), 0);
    chk("mid_rv0", 32'(bus.rsp0_valid), 0);
    chk("mid_rd0", 32'(bus.rsp0_data), 0);
    set_req(1'b1, 1'b0, 4'd0, 4'd0, 2'd0);
    cyc();
    rst_n = 1'b1;
    exp_ops = 0;
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk($sformatf("mid_post%0d_rv0", n),
          32'(bus.rsp0_valid), 0);
      chk($sformatf("mid_post%0d_busy", n), 32'(busy), 0);
    end

    // 256 back-to-back ops wrap the counter
    for (int i = 0; i < 256; i++) begin
      k = 8'(i);
      do_op($sformatf("wrap%0d", i), k[0], k[3:0], k[7:4],
            k[5:4] ^ k[1:0],
            model(k[3:0], k[7:4], k[5:4] ^ k[1:0]));
    end
    chk("wrap_zero", 32'(ops_done), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: RR_INIT, 0, requester holding priority after reset (0 or 1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports per requester i in {0,1}: req<i>_valid  input  1  request pending.
REQ-005 SHALL have port: req<i>_ready  output  1  request accepted this cycle.
REQ-006 SHALL have ports: req<i>_a  input  4, req<i>_b  input  4, req<i>_op  input  2  ALU operands and opcode (alu_machine A/B/OP encoding).
REQ-007 SHALL have port: rsp<i>_valid  output  1  result available to requester i.
REQ-008 SHALL have port: rsp<i>_data  output  5  result; bit 4 = alu_machine Extra, bits 3:0 = Out.
REQ-009 SHALL have port: rsp<i>_ready  input  1  requester i consumes result.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port: grant_id  output  1  requester owning the current transaction.
REQ-012 SHALL have port: ops_done  output  8  count of completed responses, all requesters.

Function
REQ-013 SHALL implement FSM with states IDLE, EXEC, RESP.
REQ-014 IDLE: req<i>_ready SHALL be combinational and high for exactly one requester when at least one req<i>_valid is high; both low otherwise.
REQ-015 Single valid requester SHALL be granted regardless of priority pointer.
REQ-016 Both valid in same cycle SHALL grant the requester named by the priority pointer.
REQ-017 On accept edge: latch a/b/op and grant_id, set pointer to the non-granted requester, go to EXEC.
REQ-018 EXEC: drive one shared alu_machine from latched operands; on next edge register its 5-bit result, go to RESP.
REQ-019 RESP: rsp<grant_id>_valid high, rsp<grant_id>_data = registered result, stable until rsp<grant_id>_ready sampled high.
REQ-020 On response handshake edge: go to IDLE, increment ops_done modulo 256 (255 -> 0).
REQ-021 Latency SHALL be fixed: rsp_valid visible 2 cycles after accept edge; with rsp_ready held high, next accept possible 3 cycles after previous accept.
REQ-022 req<i>_ready SHALL be low in EXEC and RESP; requests arriving then SHALL wait (no loss, no queueing beyond input hold).
REQ-023 Non-granted rsp_valid SHALL be low; rsp_data of non-granted port SHALL be 0.
REQ-024 rsp_ready while rsp_valid low SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, all ready/valid low, rsp data 0, busy 0, grant_id 0, ops_done 0, pointer RR_INIT.
REQ-026 Reset asserted in EXEC or RESP SHALL discard the in-flight transaction with no response.
REQ-027 First accept SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package alu_pkg SHALL hold: data width 4, op width 2, result width 5, FSM state type, opcode constants.
REQ-029 SHALL instantiate exactly one sub-module: alu_machine (unmodified, combinational).
REQ-030 Target size 120-400 RTL lines, no other sub-modules.

Verification
REQ-031 Single request: req0 valid a=3 b=4 op=00 -> ready0 same cycle, rsp0_valid 2 cycles later, rsp0_data=5'd7, ops_done=1.
REQ-032 Contention after reset (RR_INIT=0): both valid -> req0 granted first, req1 granted on next IDLE, then with both still valid req0 again (alternation).
REQ-033 Backpressure: hold rsp1_ready low 5 cycles in RESP -> rsp1_valid/data stable, busy=1, req0_ready=0 throughout; completes on ready.
REQ-034 Reset mid-op: assert rst_n low in EXEC -> all outputs at reset values immediately, no rsp_valid after release, ops_done=0.
REQ-035 Wrap: 256 back-to-back ops -> ops_done returns to 0; each rsp_data equals alu_machine output for its operands (all 4 opcodes covered).
REQ-036 Late request: req1 asserted during req0 EXEC -> req1_ready low until IDLE, then granted with operands intact.
